// File: rtl/lgn_pin_io.sv
// Pin front end for the LGN MNIST core: assembles a 98-byte binary image from ui_in,
// hands it to the core with a one-cycle img_valid pulse and reports the class on uo_out.
// Optional feature: define LGN_IO_READBACK_EN to allow image readback in RESULT.
module lgn_pin_io #(
    parameter int NUM_BYTES = 98,
    parameter int CLASS_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [7:0]             ui_in,
    input  logic [7:0]             uio_in,
    output logic [7:0]             uo_out,
    output logic [7:0]             uio_out,
    output logic [7:0]             uio_oe,
    output logic [8*NUM_BYTES-1:0] img_bits,
    output logic                   img_valid,
    input  logic                   core_done,
    input  logic [CLASS_W-1:0]     core_class
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

    logic                wr;
    logic                frame_start;
    logic [1:0]          state_reg, state_next;
    logic [6:0]          cnt_reg, cnt_next;
    logic                result_valid_reg, result_valid_next;
    logic                overrun_reg, overrun_next;
    logic                frame_loaded_reg, frame_loaded_next;
    logic [CLASS_W-1:0]  class_reg, class_next;
    logic                img_valid_reg, img_valid_next;
    logic [7:0]          uo_out_reg, uo_out_next;
    logic [7:0]          status_next;
    logic                write_en;
    logic [6:0]          write_idx;
    logic [7:0]          img_reg [NUM_BYTES];

    assign wr          = uio_in[0];
    assign frame_start = uio_in[1];

    // A byte is accepted either with frame_start (as byte 0) or while loading.
    assign write_en  = ena && wr && (frame_start || (state_reg == ST_LOAD));
    assign write_idx = frame_start ? 7'd0 : cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_img
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    img_reg[gi] <= 8'h00;
                end else if (write_en && (write_idx == 7'(gi))) begin
                    img_reg[gi] <= ui_in;
                end
            end
            assign img_bits[8*gi +: 8] = img_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        result_valid_next = result_valid_reg;
        overrun_next      = overrun_reg;
        frame_loaded_next = frame_loaded_reg;
        class_next        = class_reg;
        img_valid_next    = 1'b0;
        if (ena) begin
            if (frame_start) begin
                // frame_start beats everything else, including a pending core_done.
                state_next        = ST_LOAD;
                cnt_next          = wr ? 7'd1 : 7'd0;
                result_valid_next = 1'b0;
                overrun_next      = 1'b0;
                frame_loaded_next = 1'b0;
                class_next        = '0;
            end else begin
                case (state_reg)
                    ST_LOAD: begin
                        if (wr) begin
                            if (cnt_reg == LAST_BYTE) begin
                                state_next        = ST_WAIT;
                                frame_loaded_next = 1'b1;
                                img_valid_next    = 1'b1;
                            end else begin
                                cnt_next = cnt_reg + 7'd1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (wr) overrun_next = 1'b1;
                        if (core_done) begin
                            class_next        = core_class;
                            result_valid_next = 1'b1;
                            state_next        = ST_RESULT;
                        end
                    end
                    default: begin
                        if (wr) overrun_next = 1'b1;
                    end
                endcase
            end
        end
    end

    assign status_next = {result_valid_next, overrun_next,
                          (state_next == ST_LOAD) || (state_next == ST_WAIT),
                          1'b0, 4'(class_next)};

`ifdef LGN_IO_READBACK_EN
    logic [6:0] rb_reg, rb_next;
    logic       rb_active;

    assign rb_active = ena && !frame_start && uio_in[2] && (state_reg == ST_RESULT);

    always_comb begin
        rb_next = rb_reg;
        if (ena && frame_start) begin
            rb_next = 7'd0;
        end else if (rb_active) begin
            rb_next = (rb_reg == LAST_BYTE) ? 7'd0 : rb_reg + 7'd1;
        end
    end

    always_comb begin
        uo_out_next = uo_out_reg;
        if (rb_active) begin
            uo_out_next = img_bits[{rb_reg, 3'b000} +: 8];
        end else if (ena) begin
            uo_out_next = status_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rb_reg <= 7'd0;
        else        rb_reg <= rb_next;
    end
`else
    always_comb begin
        uo_out_next = ena ? status_next : uo_out_reg;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= 7'd0;
            result_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
            frame_loaded_reg <= 1'b0;
            class_reg        <= '0;
            img_valid_reg    <= 1'b0;
            uo_out_reg       <= 8'h00;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            result_valid_reg <= result_valid_next;
            overrun_reg      <= overrun_next;
            frame_loaded_reg <= frame_loaded_next;
            class_reg        <= class_next;
            img_valid_reg    <= img_valid_next;
            uo_out_reg       <= uo_out_next;
        end
    end

    assign uo_out    = uo_out_reg;
    assign uio_out   = {3'b000, frame_loaded_reg, 4'b0000};
    assign uio_oe    = 8'h10;
    assign img_valid = img_valid_reg;

endmodule

// File: tb/tb_lgn_pin_io.sv
// Directed bench for lgn_pin_io: frame load, result capture, overrun, stall, reset and
// restart, plus image readback when LGN_IO_READBACK_EN is defined.
module tb_lgn_pin_io;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [7:0]   ui_in;
    logic [7:0]   uio_in;
    logic [7:0]   uo_out;
    logic [7:0]   uio_out;
    logic [7:0]   uio_oe;
    logic [783:0] img_bits;
    logic         img_valid;
    logic         core_done;
    logic [3:0]   core_class;
    logic         rb_step;

    int checks   = 0;
    int failures = 0;

    lgn_pin_io #(.NUM_BYTES(98), .CLASS_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .uo_out     (uo_out),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .img_bits   (img_bits),
        .img_valid  (img_valid),
        .core_done  (core_done),
        .core_class (core_class)
    );

    always #5 clk = ~clk;

    // Apply pins, clock once, settle just after the edge.
    task automatic drive(input logic fs, input logic wr, input logic [7:0] data);
        uio_in = {5'b0, rb_step, fs, wr};
        ui_in  = data;
        @(posedge clk);
        #1;
    endtask

    function automatic int count_bad_bytes(input int base);
        int bad = 0;
        for (int k = 0; k < 98; k++) begin
            logic [7:0] exp_b;
            exp_b = 8'((k + base) & 255);
            if (img_bits[8*k +: 8] !== exp_b) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        core_done = 1'b0; core_class = 4'h0; rb_step = 1'b0;
        #2;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h10 || img_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: uo_out=%h uio_out=%h uio_oe=%h img_valid=%b, required 00 00 10 0",
                     uo_out, uio_out, uio_oe, img_valid);
        end
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || img_bits !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: uo_out=%h uio_out=%h img_nonzero=%b, required 00 00 0",
                     uo_out, uio_out, |img_bits);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_frame;
        int early = 0;
        int bad;
        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (uo_out !== 8'h20) begin
            failures++;
            $display("FAIL load_busy_after_start: uo_out=%h, required 20", uo_out);
        end
        for (int k = 0; k < 98; k++) begin
            drive(1'b0, 1'b1, 8'(k));
            if (k < 97 && img_valid !== 1'b0) early++;
        end
        checks++;
        if (img_valid !== 1'b1 || early != 0) begin
            failures++;
            $display("FAIL load_img_valid_pulse: img_valid=%b early_pulses=%0d, required 1 and 0", img_valid, early);
        end
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (img_valid !== 1'b0) begin
            failures++;
            $display("FAIL load_img_valid_width: img_valid=%b, required 0", img_valid);
        end
        bad = count_bad_bytes(0);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL load_img_bits: bad_bytes=%0d, required 0", bad);
        end
        checks++;
        if (uio_out !== 8'h10 || uo_out !== 8'h20) begin
            failures++;
            $display("FAIL load_status: uio_out=%h uo_out=%h, required 10 20", uio_out, uo_out);
        end
        $display("test_load_frame done");
    endtask

    task automatic test_result_capture;
        core_done = 1'b1; core_class = 4'd7;
        drive(1'b0, 1'b0, 8'h00);
        core_done = 1'b0;
        checks++;
        if (uo_out !== 8'h87) begin
            failures++;
            $display("FAIL result_capture: uo_out=%h, required 87", uo_out);
        end
        core_done = 1'b1; core_class = 4'd3;
        drive(1'b0, 1'b0, 8'h00);
        core_done = 1'b0;
        checks++;
        if (uo_out !== 8'h87) begin
            failures++;
            $display("FAIL result_done_ignored: uo_out=%h, required 87", uo_out);
        end
        $display("test_result_capture done");
    endtask

    task automatic test_readback;
`ifdef LGN_IO_READBACK_EN
        int bad = 0;
        rb_step = 1'b1;
        for (int i = 0; i < 99; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 98) ? 8'd0 : 8'(i);
            drive(1'b0, 1'b0, 8'h00);
            if (uo_out !== exp_b) bad++;
        end
        rb_step = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL readback_sequence: bad_bytes=%0d, required 0", bad);
        end
        drive(1'b0, 1'b0, 8'h00);
        checks++;
        if (uo_out !== 8'h87) begin
            failures++;
            $display("FAIL readback_exit: uo_out=%h, required 87", uo_out);
        end
        $display("test_readback done");
`else
        rb_step = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        rb_step = 1'b0;
        checks++;
        if (uo_out !== 8'h87) begin
            failures++;
            $display("FAIL readback_disabled: uo_out=%h, required 87", uo_out);
        end
        $display("test_readback (disabled build) done");
`endif
    endtask

    task automatic test_overrun;
        logic [783:0] saved;
        saved = img_bits;
        drive(1'b0, 1'b1, 8'hAA);
        checks++;
        if (uo_out !== 8'hC7 || uo_out[6] !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag: uo_out=%h, required c7", uo_out);
        end
        checks++;
        if (img_bits !== saved) begin
            failures++;
            $display("FAIL overrun_img_unchanged: img_bits changed, required unchanged");
        end
        drive(1'b1, 1'b0, 8'h00);
        checks++;
        if (uo_out !== 8'h20 || uio_out !== 8'h00) begin
            failures++;
            $display("FAIL overrun_cleared: uo_out=%h uio_out=%h, required 20 00", uo_out, uio_out);
        end
        $display("test_overrun done");
    endtask

    task automatic test_stall;
        int early = 0;
        int bad;
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, 8'(k + 100));
        ena = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'(i & 1), 8'hEE);
        ena = 1'b1;
        checks++;
        if (uo_out !== 8'h20 || img_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: uo_out=%h img_valid=%b, required 20 0", uo_out, img_valid);
        end
        for (int k = 20; k < 98; k++) begin
            drive(1'b0, 1'b1, 8'(k + 100));
            if (k < 97 && img_valid !== 1'b0) early++;
        end
        checks++;
        if (img_valid !== 1'b1 || early != 0) begin
            failures++;
            $display("FAIL stall_count: img_valid=%b early_pulses=%0d, required 1 and 0", img_valid, early);
        end
        bad = count_bad_bytes(100);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_img_bits: bad_bytes=%0d, required 0", bad);
        end
        $display("test_stall done");
    endtask

    task automatic test_reset_mid_frame;
        drive(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 50; k++) drive(1'b0, 1'b1, 8'(k ^ 8'h5A));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || img_valid !== 1'b0 ||
            img_bits !== '0 || uio_oe !== 8'h10) begin
            failures++;
            $display("FAIL reset_mid_frame: uo_out=%h uio_out=%h img_valid=%b img_nonzero=%b uio_oe=%h, required 00 00 0 0 10",
                     uo_out, uio_out, img_valid, |img_bits, uio_oe);
        end
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_reset_mid_frame done");
    endtask

    task automatic test_back_to_back;
        int early = 0;
        int bad;
        drive(1'b1, 1'b1, 8'd3);
        checks++;
        if (uo_out !== 8'h20) begin
            failures++;
            $display("FAIL b2b_start_with_write: uo_out=%h, required 20", uo_out);
        end
        for (int k = 1; k < 98; k++) begin
            drive(1'b0, 1'b1, 8'(k + 3));
            if (k < 97 && img_valid !== 1'b0) early++;
        end
        checks++;
        if (img_valid !== 1'b1 || early != 0) begin
            failures++;
            $display("FAIL b2b_img_valid: img_valid=%b early_pulses=%0d, required 1 and 0", img_valid, early);
        end
        bad = count_bad_bytes(3);
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_img_bits: bad_bytes=%0d, required 0", bad);
        end
        ena = 1'b0; core_done = 1'b1; core_class = 4'd9;
        drive(1'b0, 1'b0, 8'h00);
        ena = 1'b1;
        checks++;
        if (uo_out !== 8'h20 || uio_out !== 8'h10) begin
            failures++;
            $display("FAIL b2b_done_while_disabled: uo_out=%h uio_out=%h, required 20 10", uo_out, uio_out);
        end
        drive(1'b1, 1'b0, 8'h00);
        core_done = 1'b0;
        checks++;
        if (uo_out !== 8'h20 || uio_out !== 8'h00) begin
            failures++;
            $display("FAIL b2b_start_beats_done: uo_out=%h uio_out=%h, required 20 00", uo_out, uio_out);
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        test_reset();
        test_load_frame();
        test_result_capture();
        test_readback();
        test_overrun();
        test_stall();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lgn_pin_io.md
# lgn_pin_io

Chip-side pin front end of `tt_um_rejunity_lgn_mnist`, the counterpart of the cocotb/tb driver that pokes `ui_in`/`uio_in` and reads `uo_out`. It accepts a 28×28 binary MNIST image as 98 bytes over `ui_in`, presents the assembled 784-bit image to the logic-gate-network core with a one-cycle valid pulse, then latches the core's class index and reports it on `uo_out`. It sits between the top-level TinyTapeout pins and the LGN core.

## Interface

- `NUM_BYTES`, 98: image bytes per frame; 784 pixel bits.
- `CLASS_W`, 4: width of the class index from the core.

- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: when low, all pin inputs are ignored and state is held.
- `ui_in` in 8: image data byte.
- `uio_in` in 8: `[0]` wr strobe (level, one byte per cycle high); `[1]` frame_start; `[2]` readback step; others unused.
- `uo_out` out 8: `{result_valid, overrun, busy, 1'b0, class[3:0]}`, or a readback byte (see Configuration).
- `uio_out` out 8: `{3'b0, frame_loaded, 4'b0}`.
- `uio_oe` out 8: constant `8'h10`.
- `img_bits` out 784: image register; pixel `8k+b` is byte `k` bit `b`, pixel 0 is top-left, row-major.
- `img_valid` out 1: one-cycle pulse, image complete.
- `core_done` in 1: core result strobe.
- `core_class` in CLASS_W: class index, sampled when `core_done` is high.

## Operation

- FSM states: IDLE, LOAD, WAIT, RESULT. All sampling happens only when `ena` is high.
- frame_start (`uio_in[1]`) in any state: byte counter is set to 0, `result_valid`/`overrun`/`frame_loaded` are cleared, and the FSM goes to LOAD. If wr is also high that cycle, the byte is written as byte 0 and the counter becomes 1.
- LOAD: wr high writes `ui_in` into `img_bits[8*cnt +: 8]` and increments `cnt`. Writing byte 97 moves the FSM to WAIT, sets `frame_loaded`, and pulses `img_valid`.
- WAIT: `core_done` latches `core_class`, sets `result_valid`, and moves the FSM to RESULT. `core_done` in any other state is ignored.
- wr in IDLE, WAIT or RESULT without frame_start sets sticky `overrun`. The byte is discarded and `img_bits` is unchanged.
- `busy` = state is LOAD or WAIT.
- `img_bits` is not cleared by frame_start. Stale bits are overwritten byte by byte.
- Counter is 7 bits. It never exceeds 97 and does not wrap.
- `ena` low: no writes, no transitions, no `core_done` capture. Outputs hold.

## Timing

- Reset values:
  - state IDLE, `cnt` 0, `img_bits` 0.
  - `uo_out` 0, `uio_out` 0, `img_valid` 0.
  - `uio_oe` is `8'h10` (constant, including in reset).
- All outputs are registered except `uio_oe`.
- `img_valid` is high in the cycle after the edge that samples byte 97, for exactly one cycle.
- `uo_out` reflects a `core_done` capture one cycle after the sampling edge.
- Throughput: one byte per clock. The minimum frame is 98 consecutive wr cycles.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). Reset deassertion is synchronized by the top level and not by this block.
- frame_start in the same cycle as `core_done` in WAIT: frame_start wins and the result is dropped.

## Configuration

- `LGN_IO_READBACK_EN` defined:
  - In RESULT, `uio_in[2]` high puts the block in readback.
  - `uo_out` shows `img_bits[8*rb +: 8]`, where `rb` is a 7-bit pointer that starts at 0.
  - Each cycle with `uio_in[2]` high advances `rb`, wrapping 97→0.
  - `uio_in[2]` low returns `uo_out` to the status format.
  - frame_start clears `rb`.
- `LGN_IO_READBACK_EN` undefined: `uio_in[2]` is ignored, the `rb` logic is absent, and `uo_out` is always the status format.

## Test plan

- Reset, then idle: `uo_out`=0, `uio_out`=0, `uio_oe`=`8'h10`, `img_valid`=0.
- Load a full frame: frame_start, then 98 bytes of value `k` (byte `k` = `k`). `img_valid` pulses once, one cycle after byte 97. `img_bits[8*k +: 8]`=`k` for every `k`. `uio_out`=`8'h10`, and `uo_out[5]` (busy)=1.
- Result capture: in WAIT, `core_done`=1 with `core_class`=7. The next cycle `uo_out`=`8'h87`, and busy has dropped.
- Overrun: after RESULT, one wr without frame_start gives `uo_out[6]`=1 and `img_bits` unchanged. The next frame_start clears it, giving `uo_out`=`8'h20`.
- Stall, reset and restart:
  - `ena`=0 for 5 cycles mid-LOAD while wr toggles: `cnt` is unchanged.
  - Reset asserted at byte 50: all outputs are 0 immediately.
  - A fresh 98-byte frame then completes normally.
- With `LGN_IO_READBACK_EN`: after the frame above, in RESULT hold `uio_in[2]` for 99 cycles. `uo_out` shows 0,1,…,97,0.
